// File: rtl/sistema_pio_pkg.sv
// Shared definitions for the sistema PIO slaves: register offsets and
// edge-type encodings.
package sistema_pio_pkg;

    // s1 register offsets
    localparam logic [1:0] PIO_DATA     = 2'd0;
    localparam logic [1:0] PIO_RESERVED = 2'd1;
    localparam logic [1:0] PIO_IRQ_MASK = 2'd2;
    localparam logic [1:0] PIO_EDGE_CAP = 2'd3;

    // Which debounced transition sets an edge-capture bit
    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

endpackage

// File: rtl/sistema_button_debounce.sv
// Single-bit button conditioner: two-flop synchronizer, mismatch-count
// debouncer and rise/fall event strobes aligned with the stable update.
module sistema_button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic        IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int unsigned     CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next-state: count consecutive mismatches, accept the new level on the last one
    always_comb begin
        sync1_d  = din;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        count_d  = '0;
        rise     = 1'b0;
        fall     = 1'b0;
        if (sync2_q != stable_q) begin
            if (count_q == LAST) begin
                // Events are combinational so the capture register sets on
                // the same edge that stable changes.
                stable_d = sync2_q;
                rise     = sync2_q;
                fall     = ~sync2_q;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset drops any partial count and idles at IDLE_LEVEL
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= IDLE_LEVEL;
            sync2_q  <= IDLE_LEVEL;
            stable_q <= IDLE_LEVEL;
            count_q  <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            count_q  <= count_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/sistema_button_pio_in.sv
// Avalon-MM input PIO for the sistema push buttons: debounced DATA,
// IRQ_MASK and write-1-to-clear EDGE_CAPTURE, with a maskable level irq.
module sistema_button_pio_in
    import sistema_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned EDGE_TYPE       = 1,
    parameter logic        IDLE_LEVEL      = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] stable_w, rise_w, fall_w, edge_evt;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_mask, wr_edge;
    logic             unused_wdata;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        sistema_button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_LEVEL      (IDLE_LEVEL)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (in_port[g]),
            .stable  (stable_w[g]),
            .rise    (rise_w[g]),
            .fall    (fall_w[g])
        );
    end

    // Select which debounced transitions count as edge events
    always_comb begin
        edge_evt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            case (EDGE_TYPE)
                32'(EDGE_RISE): edge_evt[i] = rise_w[i];
                32'(EDGE_FALL): edge_evt[i] = fall_w[i];
                default:        edge_evt[i] = rise_w[i] | fall_w[i];
            endcase
        end
    end

    // Register-file next state; an edge event beats a same-cycle W1C
    always_comb begin
        wr_mask    = chipselect && !write_n && (address == PIO_IRQ_MASK);
        wr_edge    = chipselect && !write_n && (address == PIO_EDGE_CAP);
        irq_mask_d = wr_mask ? writedata[WIDTH-1:0] : irq_mask_q;
        edge_cap_d = edge_cap_q;
        if (wr_edge) begin
            edge_cap_d = edge_cap_d & ~writedata[WIDTH-1:0];
        end
        edge_cap_d = edge_cap_d | edge_evt;
    end

    // Read mux, sampled every clock regardless of chipselect
    always_comb begin
        readdata_d = '0;
        case (address)
            PIO_DATA:     readdata_d[WIDTH-1:0] = stable_w;
            PIO_IRQ_MASK: readdata_d[WIDTH-1:0] = irq_mask_q;
            PIO_EDGE_CAP: readdata_d[WIDTH-1:0] = edge_cap_q;
            default:      readdata_d = '0;
        endcase
    end

    // Registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            readdata_q <= '0;
        end else begin
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata     = readdata_q;
    assign irq          = |(edge_cap_q & irq_mask_q);
    assign unused_wdata = ^writedata;

endmodule
